// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Byte-serial program loader feeding the write port of the instruction RAM.
// Host bytes arrive least-significant first and are packed into INST_W-bit
// instruction words, which are written to consecutive RAM addresses starting
// at Load_Base.  The word is written raw, so opcode and register fields land
// wherever the instruction format places them.  The CPU is expected to stay
// off the RAM while Busy is high.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   When defined, a running BYTE_W-bit sum of all data bytes is kept.  After
//   the last word one extra checksum byte is accepted; if (sum + byte) is not
//   zero modulo 2^BYTE_W, Error is set and stays set until the next accepted
//   Load_Start.  When undefined there is no CHECK state and Error is tied 0.
//
// Ports
//   Clk          in   clock, all logic on the rising edge
//   Reset_n      in   synchronous active-low reset
//   Load_Start   in   start a load (honoured only while idle)
//   Load_Base    in   first RAM address, captured on Load_Start
//   Load_Count   in   number of instructions, captured on Load_Start
//   Byte_In      in   host data byte
//   Byte_Valid   in   Byte_In valid
//   Byte_Ready   out  loader accepts a byte (transfer = Byte_Valid & Byte_Ready)
//   Ram_We       out  RAM write strobe, one cycle per instruction
//   Ram_Addr     out  RAM write address (holds last written value)
//   Ram_Inst_In  out  packed instruction word (holds last written value)
//   Busy         out  load in progress
//   Done         out  one-cycle pulse at the end of a load
//   Error        out  checksum fault (always 0 without LOADER_CHECKSUM_EN)
//
// States
//   state     | meaning
//   S_IDLE    | waiting for Load_Start
//   S_COLLECT | accepting the bytes of one instruction word
//   S_WRITE   | one-cycle RAM write of the packed word
//   S_CHECK   | accepting the trailing checksum byte (checksum build only)
//   S_DONE    | one-cycle completion pulse
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int INST_W     = 16,
    parameter int MEM_ADDR_W = 8,
    parameter int BYTE_W     = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Load_Start,
    input  logic [MEM_ADDR_W-1:0] Load_Base,
    input  logic [MEM_ADDR_W:0]   Load_Count,
    input  logic [BYTE_W-1:0]     Byte_In,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    output logic                  Ram_We,
    output logic [MEM_ADDR_W-1:0] Ram_Addr,
    output logic [INST_W-1:0]     Ram_Inst_In,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam int NBYTES = (INST_W + BYTE_W - 1) / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BUF_W  = NBYTES * BYTE_W;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [MEM_ADDR_W:0] ONE_LEFT = (MEM_ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK   = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [IDX_W-1:0]      byte_idx;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_ADDR_W:0]   remaining;
    logic [BUF_W-1:0]      word_buf;
    logic [BUF_W-1:0]      buf_nxt;
    logic [MEM_ADDR_W-1:0] ram_addr_q;
    logic [INST_W-1:0]     ram_inst_q;

    logic                  byte_ready;
    logic                  xfer;
    logic                  last_byte;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]     sum;
    logic [BYTE_W-1:0]     sum_chk;
    logic                  error_q;
`endif

    assign xfer      = Byte_Valid & byte_ready;
    assign last_byte = (byte_idx == LAST_IDX);

    // Word buffer with the incoming byte merged in at the current position.
    // Bits above INST_W in the final byte are never forwarded to the RAM.
    always_comb begin
        buf_nxt = word_buf;
        buf_nxt[byte_idx * BYTE_W +: BYTE_W] = Byte_In;
    end

`ifdef LOADER_CHECKSUM_EN
    assign sum_chk = sum + Byte_In;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Load_Start) begin
                    if (Load_Count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = S_CHECK;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (xfer && last_byte) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (remaining == ONE_LEFT) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        byte_ready = 1'b0;
        Ram_We     = 1'b0;
        Busy       = 1'b1;
        Done       = 1'b0;
        case (state)
            S_IDLE:    Busy       = 1'b0;
            S_COLLECT: byte_ready = 1'b1;
            S_WRITE:   Ram_We     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:   byte_ready = 1'b1;
`endif
            S_DONE:    Done       = 1'b1;
            default:   Busy       = 1'b0;
        endcase
    end

    assign Byte_Ready  = byte_ready;
    assign Ram_Addr    = ram_addr_q;
    assign Ram_Inst_In = ram_inst_q;

`ifdef LOADER_CHECKSUM_EN
    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

    // ------------------------------------------------------------- datapath
    // Ram_Addr/Ram_Inst_In are loaded on the edge that accepts the last byte
    // of a word, so they change exactly as WRITE begins and then hold until
    // the next word is complete.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            byte_idx   <= '0;
            addr       <= '0;
            remaining  <= '0;
            word_buf   <= '0;
            ram_addr_q <= '0;
            ram_inst_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Load_Start) begin
                        addr      <= Load_Base;
                        remaining <= Load_Count;
                        byte_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum       <= '0;
                        error_q   <= 1'b0;
`endif
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        word_buf <= buf_nxt;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum_chk;
`endif
                        if (last_byte) begin
                            byte_idx   <= '0;
                            ram_addr_q <= addr;
                            ram_inst_q <= buf_nxt[INST_W-1:0];
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at 2^MEM_ADDR_W.
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer && (sum_chk != '0)) begin
                        error_q <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic        Clk;
    logic        Reset_n;
    logic        Load_Start;
    logic [7:0]  Load_Base;
    logic [8:0]  Load_Count;
    logic [7:0]  Byte_In;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic        Ram_We;
    logic [7:0]  Ram_Addr;
    logic [15:0] Ram_Inst_In;
    logic        Busy;
    logic        Done;
    logic        Error;

    inst_loader #(.INST_W(16), .MEM_ADDR_W(8), .BYTE_W(8)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Load_Start  (Load_Start),
        .Load_Base   (Load_Base),
        .Load_Count  (Load_Count),
        .Byte_In     (Byte_In),
        .Byte_Valid  (Byte_Valid),
        .Byte_Ready  (Byte_Ready),
        .Ram_We      (Ram_We),
        .Ram_Addr    (Ram_Addr),
        .Ram_Inst_In (Ram_Inst_In),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Writes and Done pulses observed on the falling edge.
    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          done_cnt  = 0;
    logic        done_prev = 1'b0;

    typedef struct packed {
        logic [7:0]  base;
        logic [8:0]  count;
        logic [47:0] bytes;     // byte k at [k*8 +: 8], sent in order k = 0,1,...
        logic        gaps;      // idle cycles between bytes + stray Load_Start
        logic [47:0] exp_inst;  // expected word w at [w*16 +: 16]
        logic [23:0] exp_addr;  // expected address w at [w*8 +: 8]
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (Ram_We) begin
            wr_addr_q.push_back(Ram_Addr);
            wr_data_q.push_back(Ram_Inst_In);
        end
        if (Done) begin
            done_cnt++;
            check("done_single_cycle", 32'(done_prev), 32'h0);
        end
        done_prev = Done;
    end

    task automatic start_load(input logic [7:0] base, input logic [8:0] count);
        Load_Base  = base;
        Load_Count = count;
        Load_Start = 1'b1;
        tick();
        Load_Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        Byte_In    = b;
        Byte_Valid = 1'b1;
        while (!Byte_Ready && n < 50) begin
            tick();
            n++;
        end
        if (!Byte_Ready) check("byte_ready_timeout", 32'(Byte_Ready), 32'h1);
        tick();
        Byte_Valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(done_cnt > 0 && !Busy) && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done_cnt), 32'h1);
        check("busy_after_done", 32'(Busy), 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] csum;
        csum = 8'h00;
`endif
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        start_load(v.base, v.count);
        for (int w = 0; w < int'(v.count); w++) begin
            for (int b = 0; b < 2; b++) begin
                if (v.gaps) begin
                    tick();
                    if (w == 0 && b == 1) begin
                        // stray start while busy must be ignored
                        Load_Base  = 8'hEE;
                        Load_Count = 9'd5;
                        Load_Start = 1'b1;
                    end
                    tick();
                    Load_Start = 1'b0;
                end
                send_byte(v.bytes[(w*2+b)*8 +: 8]);
`ifdef LOADER_CHECKSUM_EN
                csum = csum + v.bytes[(w*2+b)*8 +: 8];
`endif
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00 - csum);
`endif
        wait_done();
        check($sformatf("v%0d_n_writes", idx), 32'(wr_addr_q.size()), 32'(v.count));
        for (int w = 0; w < int'(v.count); w++) begin
            if (w < wr_addr_q.size()) begin
                check($sformatf("v%0d_addr%0d", idx, w), 32'(wr_addr_q[w]), 32'(v.exp_addr[w*8 +: 8]));
                check($sformatf("v%0d_inst%0d", idx, w), 32'(wr_data_q[w]), 32'(v.exp_inst[w*16 +: 16]));
            end
        end
        check($sformatf("v%0d_error", idx), 32'(Error), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          base    count  bytes                 gaps  exp_inst              exp_addr
        vecs[0] = '{8'h10, 9'd2, 48'h0000_5678_1234, 1'b0, 48'h0000_5678_1234, 24'h00_11_10};
        vecs[1] = '{8'hFF, 9'd2, 48'h0000_DDCC_BBAA, 1'b0, 48'h0000_DDCC_BBAA, 24'h00_00_FF};
        vecs[2] = '{8'h80, 9'd3, 48'h0605_0403_0201, 1'b1, 48'h0605_0403_0201, 24'h82_81_80};
        vecs[3] = '{8'h05, 9'd1, 48'h0000_0000_BEEF, 1'b0, 48'h0000_0000_BEEF, 24'h00_00_05};

        Reset_n    = 1'b0;
        Load_Start = 1'b0;
        Load_Base  = 8'h00;
        Load_Count = 9'd0;
        Byte_In    = 8'h00;
        Byte_Valid = 1'b0;
        repeat (3) tick();

        check("rst_byte_ready", 32'(Byte_Ready), 32'h0);
        check("rst_ram_we",     32'(Ram_We), 32'h0);
        check("rst_ram_addr",   32'(Ram_Addr), 32'h0);
        check("rst_ram_inst",   32'(Ram_Inst_In), 32'h0);
        check("rst_busy",       32'(Busy), 32'h0);
        check("rst_done",       32'(Done), 32'h0);
        check("rst_error",      32'(Error), 32'h0);

        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], i);
            repeat (2) tick();
        end

        // Latency: last byte accepted at edge N -> Ram_We in the following
        // cycle -> Byte_Ready again one cycle later; outputs hold afterwards.
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        start_load(8'h20, 9'd2);
        send_byte(8'h11);
        Byte_In    = 8'h22;
        Byte_Valid = 1'b1;
        check("lat_ready_before", 32'(Byte_Ready), 32'h1);
        tick();
        Byte_Valid = 1'b0;
        check("lat_we",          32'(Ram_We), 32'h1);
        check("lat_addr",        32'(Ram_Addr), 32'h20);
        check("lat_inst",        32'(Ram_Inst_In), 32'h2211);
        check("lat_ready_write", 32'(Byte_Ready), 32'h0);
        tick();
        check("lat_we_off",      32'(Ram_We), 32'h0);
        check("lat_ready_again", 32'(Byte_Ready), 32'h1);
        check("lat_addr_hold",   32'(Ram_Addr), 32'h20);
        check("lat_inst_hold",   32'(Ram_Inst_In), 32'h2211);
        send_byte(8'h33);
        send_byte(8'h44);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h56);
`endif
        wait_done();
        check("lat_n_writes",     32'(wr_addr_q.size()), 32'h2);
        check("lat_final_addr",   32'(Ram_Addr), 32'h21);
        check("lat_final_inst",   32'(Ram_Inst_In), 32'h4433);
        repeat (2) tick();

`ifndef LOADER_CHECKSUM_EN
        // Count = 0: Done in the cycle right after Load_Start is taken, no writes.
        wr_addr_q.delete();
        done_cnt = 0;
        start_load(8'h33, 9'd0);
        check("cnt0_done",      32'(Done), 32'h1);
        check("cnt0_busy",      32'(Busy), 32'h1);
        check("cnt0_we",        32'(Ram_We), 32'h0);
        tick();
        check("cnt0_done_off",  32'(Done), 32'h0);
        check("cnt0_busy_off",  32'(Busy), 32'h0);
        check("cnt0_n_writes",  32'(wr_addr_q.size()), 32'h0);
        check("cnt0_addr_hold", 32'(Ram_Addr), 32'h21);
        repeat (2) tick();
`endif

        // Reset in the middle of a Count=3 load after the first write.
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        start_load(8'h40, 9'd3);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        Reset_n = 1'b0;
        tick();
        check("abort_we",    32'(Ram_We), 32'h0);
        check("abort_addr",  32'(Ram_Addr), 32'h0);
        check("abort_inst",  32'(Ram_Inst_In), 32'h0);
        check("abort_busy",  32'(Busy), 32'h0);
        check("abort_done",  32'(Done), 32'h0);
        check("abort_ready", 32'(Byte_Ready), 32'h0);
        tick();
        Reset_n    = 1'b1;
        Byte_In    = 8'h04;
        Byte_Valid = 1'b1;
        repeat (5) tick();
        Byte_Valid = 1'b0;
        check("abort_n_writes", 32'(wr_addr_q.size()), 32'h1);
        if (wr_addr_q.size() > 0) begin
            check("abort_first_addr", 32'(wr_addr_q[0]), 32'h40);
            check("abort_first_inst", 32'(wr_data_q[0]), 32'h0201);
        end
        check("abort_no_done", 32'(done_cnt), 32'h0);
        run_vec(vecs[0], 10);
        repeat (2) tick();

`ifdef LOADER_CHECKSUM_EN
        // Good checksum: 01 + 02 + FD = 0x100 -> 0.
        done_cnt = 0;
        start_load(8'h60, 9'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hFD);
        wait_done();
        check("cks_good_error", 32'(Error), 32'h0);
        // Bad checksum: 01 + 02 + FC = 0xFF -> Error, sticky.
        done_cnt = 0;
        start_load(8'h60, 9'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hFC);
        wait_done();
        check("cks_bad_error", 32'(Error), 32'h1);
        repeat (3) tick();
        check("cks_error_sticky", 32'(Error), 32'h1);
        done_cnt = 0;
        start_load(8'h60, 9'd0);
        check("cks_error_cleared", 32'(Error), 32'h0);
        send_byte(8'h00);
        wait_done();
        check("cks_cnt0_error", 32'(Error), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
